// File: rtl/pcu_gen.sv
// rtl/pcu_gen.sv - pipeline control unit: stalls, clears, operand forwarding and memory/MDU wait FSM
// Optional feature macro: PCU_PERF_CNT_EN adds saturating stall-cycle and flush counters.

module pcu_gen #(
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LSU_TIMEOUT    = 15,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 fetch_en_i,
  input  logic [ADDR_WIDTH-1:0]                rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0]                rs2_addr_i,
  input  logic                                 rs1_used_i,
  input  logic                                 rs2_used_i,
  input  logic [NUM_FWD_STAGES*ADDR_WIDTH-1:0] stage_waddr_i,
  input  logic [NUM_FWD_STAGES-1:0]            stage_wen_i,
  input  logic [NUM_FWD_STAGES-1:0]            stage_is_load_i,
  input  logic                                 lsu_req_i,
  input  logic                                 lsu_gnt_i,
  input  logic                                 lsu_rvalid_i,
  input  logic                                 branch_taken_i,
  input  logic                                 jump_taken_i,
  input  logic                                 mdu_busy_i,
  output logic                                 fetch_stall_o,
  output logic                                 if_to_id_stall_o,
  output logic                                 id_to_ex_stall_o,
  output logic                                 ex_to_wb_stall_o,
  output logic                                 if_to_id_clear_o,
  output logic                                 id_to_ex_clear_o,
  output logic                                 ex_to_wb_clear_o,
  output logic [SEL_W-1:0]                     fwrd_opA_sel_o,
  output logic [SEL_W-1:0]                     fwrd_opB_sel_o,
  output logic                                 lsu_timeout_o,
  output logic [2:0]                           state_o
`ifdef PCU_PERF_CNT_EN
  ,
  output logic [31:0]                          stall_cycles_o,
  output logic [31:0]                          flush_count_o
`endif
);

  // The wait counter only ever holds 0 .. LSU_TIMEOUT-1 (the abort cycle leaves the state).
  localparam int CNT_W = (LSU_TIMEOUT < 2) ? 1 : $clog2(LSU_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LSU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_MEM_GNT    = 3'd2,
    ST_MEM_RVALID = 3'd3,
    ST_MDU_WAIT   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             global_stall;
  logic             timeout;
  logic             wb_is_load;
  logic [SEL_W-1:0] a_sel, b_sel;
  logic             a_load, b_load;
  logic             load_use;

  assign wb_is_load = stage_is_load_i[NUM_FWD_STAGES-1];
  assign load_use   = a_load | b_load;

  // Forwarding source per operand: the youngest matching writer wins; x0 and unused operands never forward.
  // a_load/b_load flag a selected source that is a load not yet in WB (data not available yet).
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    a_load = 1'b0;
    b_load = 1'b0;
    for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
      if (stage_wen_i[i] && rs1_used_i && (rs1_addr_i != '0) &&
          (stage_waddr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == rs1_addr_i)) begin
        a_sel  = SEL_W'(i + 1);
        a_load = stage_is_load_i[i] && (i < NUM_FWD_STAGES - 1);
      end
      if (stage_wen_i[i] && rs2_used_i && (rs2_addr_i != '0) &&
          (stage_waddr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == rs2_addr_i)) begin
        b_sel  = SEL_W'(i + 1);
        b_load = stage_is_load_i[i] && (i < NUM_FWD_STAGES - 1);
      end
    end
  end

  // Next state, memory-wait abort detection and the global stall that freezes the whole pipeline
  always_comb begin
    state_d      = state_q;
    timeout      = 1'b0;
    global_stall = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (fetch_en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (lsu_req_i && !lsu_gnt_i)                       state_d = ST_MEM_GNT;
        else if (lsu_req_i && wb_is_load && !lsu_rvalid_i) state_d = ST_MEM_RVALID;
        else if (mdu_busy_i)                               state_d = ST_MDU_WAIT;
        else if (!fetch_en_i)                              state_d = ST_IDLE;
        // The cycle that enters a wait state is already frozen.
        global_stall = (state_d != ST_RUN) && (state_d != ST_IDLE);
      end
      ST_MEM_GNT: begin
        if (lsu_gnt_i) begin
          state_d = (wb_is_load && !lsu_rvalid_i) ? ST_MEM_RVALID : ST_RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_MEM_RVALID: begin
        if (lsu_rvalid_i) begin
          state_d = ST_RUN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_MDU_WAIT: begin
        if (!mdu_busy_i) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cycles already spent in the current memory-wait state; restarts on every entry
  always_comb begin
    cnt_d = '0;
    if (((state_q == ST_MEM_GNT) || (state_q == ST_MEM_RVALID)) && (state_d == state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FSM state and wait-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pipeline register stall/clear controls, highest priority first
  always_comb begin
    fetch_stall_o    = 1'b0;
    if_to_id_stall_o = 1'b0;
    id_to_ex_stall_o = 1'b0;
    ex_to_wb_stall_o = 1'b0;
    if_to_id_clear_o = 1'b0;
    id_to_ex_clear_o = 1'b0;
    ex_to_wb_clear_o = 1'b0;
    if (global_stall) begin
      fetch_stall_o    = 1'b1;
      if_to_id_stall_o = 1'b1;
      id_to_ex_stall_o = 1'b1;
      ex_to_wb_stall_o = 1'b1;
      // An aborted memory op is flushed out of EX/WB; the clear wins over the stall at the register.
      ex_to_wb_clear_o = timeout;
    end else if (branch_taken_i) begin
      if_to_id_clear_o = 1'b1;
      id_to_ex_clear_o = 1'b1;
    end else if (load_use) begin
      fetch_stall_o    = 1'b1;
      if_to_id_stall_o = 1'b1;
      id_to_ex_clear_o = 1'b1;
    end else if (jump_taken_i) begin
      // A load-use hold keeps the jump in ID, so its IF/ID flush waits until the hazard clears.
      if_to_id_clear_o = 1'b1;
    end
  end

  // Operand mux selects: register file while idle or while the source load is still in flight
  always_comb begin
    fwrd_opA_sel_o = ((state_q == ST_IDLE) || a_load) ? '0 : a_sel;
    fwrd_opB_sel_o = ((state_q == ST_IDLE) || b_load) ? '0 : b_sel;
  end

  assign lsu_timeout_o = timeout;
  assign state_o       = state_q;

`ifdef PCU_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating counters of fetch-stall cycles outside IDLE and of IF/ID flush cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (fetch_stall_o && (state_q != ST_IDLE) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (if_to_id_clear_o && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_d = flush_count_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pcu_gen.sv
// tb/tb_pcu_gen.sv - randomized self-checking bench for pcu_gen against a behavioural model
`timescale 1ns/1ps
module tb_pcu_gen;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int TO = 4;
  localparam int SW = $clog2(NS + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             fetch_en;
  logic [AW-1:0]    rs1_addr, rs2_addr;
  logic             rs1_used, rs2_used;
  logic [NS*AW-1:0] stage_waddr;
  logic [NS-1:0]    stage_wen, stage_is_load;
  logic             lsu_req, lsu_gnt, lsu_rvalid;
  logic             branch, jump, mdu_busy;
  logic             fetch_stall, ifid_stall, idex_stall, exwb_stall;
  logic             ifid_clr, idex_clr, exwb_clr;
  logic [SW-1:0]    sel_a, sel_b;
  logic             lsu_timeout;
  logic [2:0]       state;
`ifdef PCU_PERF_CNT_EN
  logic [31:0]      stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  pcu_gen #(.ADDR_WIDTH(AW), .NUM_FWD_STAGES(NS), .LSU_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_used_i(rs1_used), .rs2_used_i(rs2_used),
    .stage_waddr_i(stage_waddr), .stage_wen_i(stage_wen), .stage_is_load_i(stage_is_load),
    .lsu_req_i(lsu_req), .lsu_gnt_i(lsu_gnt), .lsu_rvalid_i(lsu_rvalid),
    .branch_taken_i(branch), .jump_taken_i(jump), .mdu_busy_i(mdu_busy),
    .fetch_stall_o(fetch_stall), .if_to_id_stall_o(ifid_stall), .id_to_ex_stall_o(idex_stall),
    .ex_to_wb_stall_o(exwb_stall), .if_to_id_clear_o(ifid_clr), .id_to_ex_clear_o(idex_clr),
    .ex_to_wb_clear_o(exwb_clr), .fwrd_opA_sel_o(sel_a), .fwrd_opB_sel_o(sel_b),
    .lsu_timeout_o(lsu_timeout), .state_o(state)
`ifdef PCU_PERF_CNT_EN
    , .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = 0, m_next = 0;
  int m_wait = 0, m_wait_next = 0;
  bit m_known = 0, m_known_next = 0;
  longint m_sc = 0, m_sc_next = 0, m_fc = 0, m_fc_next = 0;

  // Index of the youngest stage writing register r, or -1 when nothing forwards.
  function automatic int fwd_src(input logic [AW-1:0] r, input logic used);
    if (!used || r == '0) return -1;
    for (int i = 0; i < NS; i++)
      if (stage_wen[i] && stage_waddr[i*AW +: AW] == r) return i;
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    int sa, sb, nxt, e_sa, e_sb;
    bit ha, hb, stalled, tmo, ld_wb;
    bit e_fs, e_is, e_es, e_ws, e_ic, e_ec, e_wc;
    sa = fwd_src(rs1_addr, rs1_used);
    sb = fwd_src(rs2_addr, rs2_used);
    ha = (sa >= 0 && sa < NS - 1) ? stage_is_load[sa] : 1'b0;
    hb = (sb >= 0 && sb < NS - 1) ? stage_is_load[sb] : 1'b0;
    ld_wb = stage_is_load[NS-1];
    tmo = 0;
    stalled = 1;
    case (m_state)
      0: nxt = fetch_en ? 1 : 0;
      1: begin
        if (lsu_req && !lsu_gnt)                nxt = 2;
        else if (lsu_req && ld_wb && !lsu_rvalid) nxt = 3;
        else if (mdu_busy)                      nxt = 4;
        else                                    nxt = fetch_en ? 1 : 0;
        stalled = (nxt >= 2);
      end
      2: begin
        if (lsu_gnt)               nxt = (ld_wb && !lsu_rvalid) ? 3 : 1;
        else if (m_wait + 1 == TO) begin tmo = 1; nxt = 1; end
        else                       nxt = 2;
      end
      3: begin
        if (lsu_rvalid)            nxt = 1;
        else if (m_wait + 1 == TO) begin tmo = 1; nxt = 1; end
        else                       nxt = 3;
      end
      default: nxt = mdu_busy ? 4 : 1;
    endcase
    e_fs = stalled; e_is = stalled; e_es = stalled; e_ws = stalled;
    e_ic = 0; e_ec = 0; e_wc = tmo;
    if (!stalled) begin
      if (branch)        begin e_ic = 1; e_ec = 1; end
      else if (ha || hb) begin e_fs = 1; e_is = 1; e_ec = 1; end
      else if (jump)     e_ic = 1;
    end
    e_sa = (m_state == 0 || sa < 0 || ha) ? 0 : sa + 1;
    e_sb = (m_state == 0 || sb < 0 || hb) ? 0 : sb + 1;
    if (m_known) begin
      chk("state", state, m_state);
      chk("fetch_stall", fetch_stall, e_fs);
      chk("if_to_id_stall", ifid_stall, e_is);
      chk("id_to_ex_stall", idex_stall, e_es);
      chk("ex_to_wb_stall", exwb_stall, e_ws);
      chk("if_to_id_clear", ifid_clr, e_ic);
      chk("id_to_ex_clear", idex_clr, e_ec);
      chk("ex_to_wb_clear", exwb_clr, e_wc);
      chk("lsu_timeout", lsu_timeout, tmo);
      chk("fwrd_opA_sel", sel_a, e_sa);
      chk("fwrd_opB_sel", sel_b, e_sb);
`ifdef PCU_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, 32'(m_sc));
      chk("flush_count", flush_count, 32'(m_fc));
`endif
    end
    m_next       = rst_n ? nxt : 0;
    m_wait_next  = (rst_n && nxt == m_state && (m_state == 2 || m_state == 3)) ? m_wait + 1 : 0;
    m_known_next = m_known | !rst_n;
    m_sc_next    = !rst_n ? 0 : ((e_fs && m_state != 0 && m_sc < 64'hFFFF_FFFF) ? m_sc + 1 : m_sc);
    m_fc_next    = !rst_n ? 0 : ((e_ic && m_fc < 64'hFFFF_FFFF) ? m_fc + 1 : m_fc);
  end

  always @(posedge clk) begin
    m_state = m_next;
    m_wait  = m_wait_next;
    m_known = m_known_next;
    m_sc    = m_sc_next;
    m_fc    = m_fc_next;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    fetch_en = 1; rs1_addr = '0; rs2_addr = '0; rs1_used = 0; rs2_used = 0;
    stage_waddr = '0; stage_wen = '0; stage_is_load = '0;
    lsu_req = 0; lsu_gnt = 0; lsu_rvalid = 0; branch = 0; jump = 0; mdu_busy = 0;
  endtask

  logic [6:0] req_pat, gnt_pat, rv_pat;
  int st_tab[7];
  int nstall;

  initial begin
    rst_n = 0;
    clr_in();
    fetch_en = 0;
    repeat (2) step();
    rst_n = 1;
    // reset state, IDLE until fetch enabled
    #1;
    chk("rst_state", state, 0);
    chk("rst_stalls", {fetch_stall, ifid_stall, idex_stall, exwb_stall}, 4'b1111);
    chk("rst_clears", {ifid_clr, idex_clr, exwb_clr}, 3'b000);
    chk("rst_sel", {sel_a, sel_b}, 0);
    chk("rst_timeout", lsu_timeout, 0);
    step();
    fetch_en = 1;
    #1;
    chk("idle_c3_state", state, 0);
    chk("idle_c3_stall", fetch_stall, 1);
    step();
    #1;
    chk("run_state", state, 1);
    chk("run_stall", {fetch_stall, ifid_stall, idex_stall, exwb_stall}, 4'b0000);

    // forwarding priority, x0 and unused operands
    step();
    stage_waddr = {5'd5, 5'd5}; stage_wen = 2'b11;
    rs1_addr = 5'd5; rs1_used = 1; rs2_addr = 5'd0; rs2_used = 1;
    #1;
    chk("fwd_ex_a", sel_a, 1);
    chk("fwd_ex_b", sel_b, 0);
    step();
    stage_wen = 2'b10;
    #1;
    chk("fwd_wb_a", sel_a, 2);
    step();
    stage_waddr = '0; stage_wen = 2'b11; rs1_addr = 5'd0;
    #1;
    chk("fwd_x0", {sel_a, sel_b}, 0);
    step();
    stage_waddr = {5'd5, 5'd5}; rs1_addr = 5'd5; rs1_used = 0;
    #1;
    chk("fwd_unused", sel_a, 0);

    // load-use hazard on rs2 with the load in EX, then the load in WB
    step();
    clr_in();
    stage_waddr = {5'd0, 5'd7}; stage_wen = 2'b01; stage_is_load = 2'b01;
    rs1_addr = 5'd3; rs1_used = 1; rs2_addr = 5'd7; rs2_used = 1;
    #1;
    chk("lu_fetch_stall", fetch_stall, 1);
    chk("lu_ifid_stall", ifid_stall, 1);
    chk("lu_idex_clear", idex_clr, 1);
    chk("lu_idex_stall", idex_stall, 0);
    chk("lu_sel_b", sel_b, 0);
    step();
    stage_waddr = {5'd7, 5'd0}; stage_wen = 2'b10; stage_is_load = 2'b10;
    #1;
    chk("lu_wb_sel_b", sel_b, 2);
    chk("lu_wb_fetch_stall", fetch_stall, 0);
    chk("lu_wb_idex_clear", idex_clr, 0);

    // WB load: gnt two cycles late, rvalid three cycles after gnt
    req_pat = 7'b0111111; gnt_pat = 7'b0000100; rv_pat = 7'b0100000;
    st_tab = '{1, 2, 2, 3, 3, 3, 1};
    nstall = 0;
    for (int t = 0; t < 7; t++) begin
      step();
      clr_in();
      stage_is_load = 2'b10;
      lsu_req = req_pat[t]; lsu_gnt = gnt_pat[t]; lsu_rvalid = rv_pat[t];
      #1;
      chk("ld_state", state, st_tab[t]);
      chk("ld_clears", {ifid_clr, idex_clr, exwb_clr}, 3'b000);
      if (fetch_stall) nstall++;
    end
    chk("ld_stall_cycles", nstall, 6);

    // gnt never arrives: abort on the 4th wait cycle
    step();
    lsu_req = 1; lsu_gnt = 0; lsu_rvalid = 0; stage_is_load = 2'b00;
    #1;
    chk("to_enter_state", state, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      #1;
      chk("to_state", state, 2);
      chk("to_pulse", lsu_timeout, (k == 4));
      chk("to_exwb_clear", exwb_clr, (k == 4));
    end
    step();
    lsu_req = 0;
    #1;
    chk("to_back_run", state, 1);
    chk("to_pulse_end", lsu_timeout, 0);

    // branch held while waiting for rvalid takes effect after the wait
    step();
    lsu_req = 1; lsu_gnt = 1; lsu_rvalid = 0; stage_is_load = 2'b10;
    step();
    lsu_gnt = 0; branch = 1;
    #1;
    chk("br_wait_state", state, 3);
    chk("br_wait_clears", {ifid_clr, idex_clr}, 2'b00);
    step();
    lsu_rvalid = 1;
    #1;
    chk("br_rv_clears", {ifid_clr, idex_clr}, 2'b00);
    step();
    lsu_req = 0; lsu_rvalid = 0;
    #1;
    chk("br_after_state", state, 1);
    chk("br_after_clears", {ifid_clr, idex_clr}, 2'b11);
    step();
    branch = 0;

    // randomized traffic checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n      = ($urandom_range(0, 199) != 0);
      fetch_en   = ($urandom_range(0, 15) != 0);
      rs1_addr   = AW'($urandom_range(0, 3));
      rs2_addr   = AW'($urandom_range(0, 3));
      rs1_used   = 1'($urandom);
      rs2_used   = 1'($urandom);
      for (int i = 0; i < NS; i++) stage_waddr[i*AW +: AW] = AW'($urandom_range(0, 3));
      stage_wen     = NS'($urandom);
      stage_is_load = NS'($urandom);
      lsu_req    = ($urandom_range(0, 5) == 0);
      lsu_gnt    = ($urandom_range(0, 2) == 0);
      lsu_rvalid = ($urandom_range(0, 2) == 0);
      branch     = ($urandom_range(0, 7) == 0);
      jump       = ($urandom_range(0, 7) == 0);
      mdu_busy   = ($urandom_range(0, 4) == 0);
    end
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
